// File: rtl/mac4b_seq.sv
// Dot-product sequencer for the 4-lane uint8 x int8 MAC: one command, N operand beats, one 32-bit result.
// Build option: define MAC4B_SEQ_RELU_EN to clamp negative results to zero on res_o (accumulator unaffected).
module mac4b_seq #(
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic [31:0]      cmd_init_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    input  logic [31:0]      act_i,
    input  logic [31:0]      wgt_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [31:0]      res_o,
    output logic             busy_o
);

    // state | meaning
    // IDLE  | waiting for a command
    // RUN   | accepting operand beats
    // DRAIN | last product still in the pipe register
    // DONE  | result presented, waiting for handshake
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   remaining;
    logic [31:0]        acc;
    logic signed [17:0] pipe;
    logic               pipe_v;
    logic               cmd_hs, data_hs, res_hs;
    logic signed [17:0] mac_sum;

    // Activations are unsigned bytes, weights signed; the 4-lane sum always fits 18 bits.
    always_comb begin
        logic signed [17:0] a_ext, w_ext;
        mac_sum = '0;
        for (int k = 0; k < 4; k++) begin
            a_ext   = {10'd0, act_i[8*k +: 8]};
            w_ext   = {{10{wgt_i[8*k+7]}}, wgt_i[8*k +: 8]};
            mac_sum = mac_sum + a_ext * w_ext;
        end
    end

    assign cmd_ready_o  = (state == IDLE);
    assign data_ready_o = (state == RUN);
    assign res_valid_o  = (state == DONE);
    assign busy_o       = (state != IDLE);

    assign cmd_hs  = cmd_valid_i  && cmd_ready_o;
    assign data_hs = data_valid_i && data_ready_o;
    assign res_hs  = res_valid_o  && res_ready_i;

`ifdef MAC4B_SEQ_RELU_EN
    assign res_o = acc[31] ? 32'd0 : acc;
`else
    assign res_o = acc;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_hs) state_nxt = (cmd_len_i != '0) ? RUN : DONE;
            RUN:     if (data_hs && remaining == LEN_W'(1)) state_nxt = DRAIN;
            DRAIN:   if (pipe_v) state_nxt = DONE;
            DONE:    if (res_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            remaining <= '0;
            acc       <= '0;
            pipe      <= '0;
            pipe_v    <= 1'b0;
        end else begin
            state <= state_nxt;

            if (cmd_hs)
                remaining <= cmd_len_i;
            else if (data_hs)
                remaining <= remaining - LEN_W'(1);

            pipe_v <= data_hs;
            if (data_hs)
                pipe <= mac_sum;

            if (cmd_hs)
                acc <= cmd_init_i;
            else if (pipe_v)
                acc <= acc + {{14{pipe[17]}}, pipe};
        end
    end

endmodule

// File: doc/mac4b_seq.md
Name: mac4b_seq

Overview:
- Sequencer for the 4-lane uint8×int8 MAC datapath (mac4b). Accepts a dot-product command, streams N packed 32-bit activation/weight word pairs through the MAC, and accumulates the results into a 32-bit register.
- Returns one 32-bit result per command over a valid/ready handshake.
- Sits between the coprocessor command/operand interface and the MAC datapath.

Parameters:
- LEN_W, 16, width of the beat-count field; maximum command length is 2^LEN_W-1 beats.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- cmd_len_i  in  LEN_W  number of data beats (4 MACs per beat)
- cmd_init_i  in  32  signed initial accumulator value (bias)
- data_valid_i  in  1  operand beat valid
- data_ready_o  out  1  operand beat ready
- act_i  in  32  4× uint8 activations; lane k = bits [8k+7:8k]
- wgt_i  in  32  4× int8 weights; lane k = bits [8k+7:8k]
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result ready
- res_o  out  32  signed result
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; beat counter, accumulator, pipe register and pipe-valid cleared.
  - Outputs: cmd_ready_o=1, data_ready_o=0, res_valid_o=0, res_o=0, busy_o=0.
  - Reset asserted mid-command aborts the command with no result.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - cmd_ready_o=1.
  - On cmd handshake: acc<=cmd_init_i and remaining<=cmd_len_i.
  - Next state is RUN if cmd_len_i!=0, else DONE.
- RUN:
  - data_ready_o=1.
  - Each data handshake: mac4b sum of (act_i, wgt_i) registered into pipe (pipe_v<=1), remaining decrements.
  - Cycles without a beat set pipe_v<=0.
  - When the handshake consumes the last beat (remaining==1), next state is DRAIN.
- DRAIN:
  - data_ready_o=0.
  - Pipe holds the last product; after it is added, next state is DONE.
- Accumulation: every cycle with pipe_v=1, acc<=acc+sext(pipe), in any state. The addition is two's-complement modulo 2^32 and wraps without saturation.
- DONE:
  - res_valid_o=1 and res_o=acc (after the optional clamp).
  - res_o stays stable while res_valid_o=1 and res_ready_i=0.
  - On res handshake, next state is IDLE.
- Latency:
  - Command handshake in cycle 0 with gap-free data: beats are accepted in cycles 1..N and res_valid_o rises in cycle N+2.
  - cmd_len_i=0: res_valid_o rises in cycle 1 with res_o=cmd_init_i.
- Input sampling: data_valid_i outside RUN is ignored and not consumed. cmd_valid_i outside IDLE is not accepted (cmd_ready_o=0).
- Back-to-back commands: a new command is accepted only in the cycle after the result handshake (IDLE). There is no overlap.
- MAC width: lane products are 16-bit signed and the 4-lane sum is sign-extended to 32 bits. Per-beat range is [-130560, +129540].

Optional Feature:
- MAC4B_SEQ_RELU_EN:
  - Defined: res_o = acc[31] ? 0 : acc, i.e. ReLU on the output only. The internal accumulator is unchanged.
  - Undefined: res_o = acc (raw two's complement).

Test Plan:
- Basic: cmd len=3, init=0; act=0x01010101, wgt=0x02020202 on 3 gap-free beats -> res_o=24 (0x00000018), res_valid_o in cycle 5.
- Signed extreme: len=1, init=0, act=0xFFFFFFFF, wgt=0x80808080 -> res_o=-130560 (0xFFFE0200). With MAC4B_SEQ_RELU_EN -> res_o=0.
- Zero length with backpressure: len=0, init=5 -> res_valid_o in cycle 1, res_o=5. Holding res_ready_i=0 for 5 cycles keeps res_o stable. cmd_ready_o=0 until the cycle after the handshake.
- Stalls and wrap: len=2, init=0x7FFFFFFF, act=0x00000001, wgt=0x00000002, with data_valid_i gaps of 3 cycles between beats -> res_o=0x80000003. data_ready_o=0 in DRAIN/DONE.
- Reset mid-op: len=4, assert rst_i after beat 2 -> all outputs return to reset values immediately. A following cmd len=1, init=0, act=0x00000003, wgt=0x000000FF (-1) -> res_o=-3.
- Back-to-back: two commands (len=1, init=1; len=1, init=2) with act=wgt=0 -> results 1 then 2. No beat of the second command is accepted before the first result handshake.
